// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/slt, iterative 1-bit-per-cycle shifts.
// Optional overflow output enabled by defining ALU_OVERFLOW_EN.
module alu_exec_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [3:0]         ctrl_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [DATA_W-1:0]  result_o,
  output logic               zero_o,
  output logic               valid_o,
  input  logic               ready_i
`ifdef ALU_OVERFLOW_EN
  ,
  output logic               overflow_o
`endif
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpNor  = 4'b1100;
  localparam logic [3:0] OpNand = 4'b1101;

  localparam logic [SHAMT_W-1:0] CntZero = '0;
  localparam logic [SHAMT_W-1:0] CntOne  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [DATA_W-1:0]   r_work, w_work_d;
  logic [DATA_W-1:0]   r_result, w_result_d;
  logic [SHAMT_W-1:0]  r_cnt, w_cnt_d;
  logic                r_dir_right, w_dir_right_d;
  logic                r_zero, w_zero_d;

  logic [DATA_W-1:0]   w_sum, w_diff, w_alu_res, w_shifted;
  logic                w_is_shift;

  // Combinational ALU on the live inputs; only used on the accepting edge.
  always_comb begin
    w_sum     = src1_i + src2_i;
    w_diff    = src1_i - src2_i;
    w_alu_res = '0;
    case (ctrl_i)
      OpAnd:        w_alu_res = src1_i & src2_i;
      OpOr:         w_alu_res = src1_i | src2_i;
      OpAdd:        w_alu_res = w_sum;
      OpSub:        w_alu_res = w_diff;
      OpSlt:        w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OpSll, OpSrl: w_alu_res = src2_i;
      OpNor:        w_alu_res = ~(src1_i | src2_i);
      OpNand:       w_alu_res = ~(src1_i & src2_i);
      default:      w_alu_res = '0;
    endcase
  end

  assign w_is_shift = (ctrl_i == OpSll) || (ctrl_i == OpSrl);
  assign w_shifted  = r_dir_right ? (r_work >> 1) : (r_work << 1);

`ifdef ALU_OVERFLOW_EN
  logic r_ovf, w_ovf_d, w_alu_ovf;

  always_comb begin
    w_alu_ovf = 1'b0;
    if (ctrl_i == OpAdd) begin
      w_alu_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) &&
                  (w_sum[DATA_W-1] != src1_i[DATA_W-1]);
    end else if (ctrl_i == OpSub) begin
      w_alu_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
                  (w_diff[DATA_W-1] != src1_i[DATA_W-1]);
    end
  end
`endif

  always_comb begin
    w_state_d     = r_state;
    w_work_d      = r_work;
    w_result_d    = r_result;
    w_cnt_d       = r_cnt;
    w_dir_right_d = r_dir_right;
    w_zero_d      = r_zero;
`ifdef ALU_OVERFLOW_EN
    w_ovf_d       = r_ovf;
`endif
    case (r_state)
      StIdle: begin
        if (valid_i) begin
          if (w_is_shift && (shamt_i != CntZero)) begin
            w_work_d      = src2_i;
            w_cnt_d       = shamt_i;
            w_dir_right_d = (ctrl_i == OpSrl);
            w_state_d     = StShift;
          end else begin
            w_result_d = w_alu_res;
            w_zero_d   = (w_alu_res == '0);
`ifdef ALU_OVERFLOW_EN
            w_ovf_d    = w_alu_ovf;
`endif
            w_state_d  = StDone;
          end
        end
      end
      StShift: begin
        w_work_d = w_shifted;
        w_cnt_d  = r_cnt - CntOne;
        // Last shift step writes the result directly so DONE follows k shift edges.
        if (r_cnt == CntOne) begin
          w_result_d = w_shifted;
          w_zero_d   = (w_shifted == '0);
`ifdef ALU_OVERFLOW_EN
          w_ovf_d    = 1'b0;
`endif
          w_state_d  = StDone;
        end
      end
      StDone: begin
        if (ready_i) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= StIdle;
      r_work      <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_dir_right <= 1'b0;
      r_zero      <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_work      <= w_work_d;
      r_result    <= w_result_d;
      r_cnt       <= w_cnt_d;
      r_dir_right <= w_dir_right_d;
      r_zero      <= w_zero_d;
`ifdef ALU_OVERFLOW_EN
      r_ovf       <= w_ovf_d;
`endif
    end
  end

  assign ready_o  = (r_state == StIdle);
  assign valid_o  = (r_state == StDone);
  assign result_o = r_result;
  assign zero_o   = r_zero;
`ifdef ALU_OVERFLOW_EN
  assign overflow_o = r_ovf;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
// Overflow vectors run only when ALU_OVERFLOW_EN is defined.
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  ctrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [4:0]  shamt_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        valid_o;
  logic        ready_i;
`ifdef ALU_OVERFLOW_EN
  logic        overflow_o;
  logic        last_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) u_dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .shamt_i  (shamt_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow_o (overflow_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op with ready_i high, scramble inputs after capture, wait for the result.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit saw_ready;
    check_eq({tag, " rdy_in"}, {31'b0, ready_o}, 32'd1);
    valid_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh;
    tick();
    valid_i = 1'b0;
    ctrl_i  = 4'b0011; src1_i = ~a; src2_i = ~b; shamt_i = ~sh;
    lat = 1;
    saw_ready = 1'b0;
    while (!valid_o && lat < 64) begin
      if (ready_o) saw_ready = 1'b1;
      tick();
      lat++;
    end
    check_eq({tag, " lat"},  lat, exp_lat);
    check_eq({tag, " res"},  result_o, exp_res);
    check_eq({tag, " zero"}, {31'b0, zero_o}, {31'b0, (exp_res == 32'd0)});
    check_eq({tag, " busy"}, {31'b0, saw_ready | ready_o}, 32'd0);
`ifdef ALU_OVERFLOW_EN
    last_ovf = overflow_o;
`endif
    tick();
    check_eq({tag, " idle"}, {30'b0, ready_o, valid_o}, 32'b10);
  endtask

  initial begin
    bit stale;
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    ctrl_i = 4'b0; src1_i = '0; src2_i = '0; shamt_i = '0;
    tick(); tick();
    rst_i = 1'b1;
    check_eq("rst ready", {31'b0, ready_o}, 32'd1);
    check_eq("rst valid", {31'b0, valid_o}, 32'd0);
    check_eq("rst res",   result_o, 32'd0);
    check_eq("rst zero",  {31'b0, zero_o}, 32'd0);

    // Reset in the middle of a 20-step shift.
    valid_i = 1'b1; ctrl_i = 4'b1000; src2_i = 32'h1; shamt_i = 5'd20;
    tick();
    valid_i = 1'b0;
    tick(); tick();
    check_eq("mid shift ready", {31'b0, ready_o}, 32'd0);
    rst_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    check_eq("rst2 ready", {31'b0, ready_o}, 32'd1);
    check_eq("rst2 valid", {31'b0, valid_o}, 32'd0);
    check_eq("rst2 res",   result_o, 32'd0);
    check_eq("rst2 zero",  {31'b0, zero_o}, 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (valid_o || result_o != 32'd0) stale = 1'b1;
      tick();
    end
    check_eq("no stale", {31'b0, stale}, 32'd0);

    run_op("add",     4'b0010, 32'h0000_0005, 32'hFFFF_FFFB, 5'd0, 32'h0000_0000, 1);
    run_op("and",     4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3, 32'h00F0_1200, 1);
    run_op("or",      4'b0001, 32'hF000_0001, 32'h0000_0F00, 5'd0, 32'hF000_0F01, 1);
    run_op("nor",     4'b1100, 32'hF000_0001, 32'h0000_0F00, 5'd0, 32'h0FFF_F0FE, 1);
    run_op("slt neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001, 1);
    run_op("slt pos", 4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1);
    run_op("sub",     4'b0110, 32'h0000_0007, 32'h0000_0007, 5'd0, 32'h0000_0000, 1);
    run_op("sub wrap",4'b0110, 32'h0000_0003, 32'h0000_0005, 5'd0, 32'hFFFF_FFFE, 1);
    run_op("sll 31",  4'b1000, 32'h1234_5678, 32'h0000_0001, 5'd31, 32'h8000_0000, 32);
    run_op("srl 4",   4'b1001, 32'h0000_0000, 32'h8000_0000, 5'd4, 32'h0800_0000, 5);
    run_op("sll 0",   4'b1000, 32'h0000_0000, 32'h1234_5678, 5'd0, 32'h1234_5678, 1);
    run_op("srl 8",   4'b1001, 32'h0000_0000, 32'hF000_0000, 5'd8, 32'h00F0_0000, 9);
    run_op("undef",   4'b0011, 32'h1234_5678, 32'h0000_0001, 5'd0, 32'h0000_0000, 1);
`ifdef ALU_OVERFLOW_EN
    run_op("add ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1);
    check_eq("add ovf flag", {31'b0, last_ovf}, 32'd1);
    run_op("sub ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1);
    check_eq("sub ovf flag", {31'b0, last_ovf}, 32'd1);
    run_op("add novf", 4'b0010, 32'h0000_0005, 32'hFFFF_FFFB, 5'd0, 32'h0000_0000, 1);
    check_eq("add novf flag", {31'b0, last_ovf}, 32'd0);
`endif

    // Backpressure: result held in DONE while ready_i is low; new requests ignored.
    ready_i = 1'b0;
    valid_i = 1'b1; ctrl_i = 4'b1101; src1_i = 32'hFFFF_0000; src2_i = 32'hFF00_FF00;
    shamt_i = 5'd0;
    tick();
    ctrl_i = 4'b0000; src1_i = 32'h0; src2_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      valid_i = i[0];
      check_eq("bp valid", {31'b0, valid_o}, 32'd1);
      check_eq("bp res",   result_o, 32'h00FF_FFFF);
      check_eq("bp ready", {31'b0, ready_o}, 32'd0);
      tick();
    end
    valid_i = 1'b0;
    check_eq("bp res end", result_o, 32'h00FF_FFFF);
    ready_i = 1'b1;
    tick();
    check_eq("bp release", {30'b0, ready_o, valid_o}, 32'b10);
    tick();
    check_eq("bp no accept", {30'b0, ready_o, valid_o}, 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that sits directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU operation code together with the two register/immediate operands and the shift amount.
- Produces a registered 32-bit result and a zero flag for the branch/writeback logic.
- Logic ops, add/sub and slt complete in one cycle. Shifts run iteratively, one bit per cycle, behind a valid/ready handshake on both sides.

Parameters:
DATA_W, 32, operand/result width
SHAMT_W, 5, shift-amount width; max shift is 2^SHAMT_W-1

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous, active-low reset
valid_i  in  1  operation request present
ready_o  out  1  unit can accept a request
ctrl_i  in  4  ALU operation code: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001, NOR 1100, NAND 1101
src1_i  in  DATA_W  operand rs
src2_i  in  DATA_W  operand rt/immediate; this is the operand that shifts act on
shamt_i  in  SHAMT_W  shift amount
result_o  out  DATA_W  registered result
zero_o  out  1  high when result_o == 0; valid only while valid_o is high
valid_o  out  1  result available
ready_i  in  1  consumer accepts the result

Behaviour:
- Reset (rst_i low at a clock edge): state returns to IDLE.
  - result_o = 0, zero_o = 0, valid_o = 0, ready_o = 1 after the edge.
  - Any in-flight shift is aborted and discarded.
- States:
  - IDLE: ready_o = 1, valid_o = 0.
  - SHIFT: ready_o = 0, valid_o = 0.
  - DONE: ready_o = 0, valid_o = 1.
- Acceptance: valid_i & ready_o at an edge captures ctrl_i, src1_i, src2_i and shamt_i. Input changes after capture are ignored.
- Non-shift op accepted in cycle N:
  - result is computed and registered at that edge, state -> DONE.
  - valid_o is high from cycle N+1 (latency 1).
- Operation results:
  - ADD/SUB: modulo 2^DATA_W; carry discarded.
  - SLT: signed compare, result = {0..0, src1 < src2}.
  - NOR = ~(a|b); NAND = ~(a&b).
- Undefined ctrl_i code: result 0, latency 1, no error flag.
- SLL/SRL, shamt = 0: behaves as a 1-cycle op; result = src2.
- SLL/SRL, shamt = k > 0:
  - working register loaded with src2, remaining count loaded with k, state -> SHIFT.
  - Each SHIFT cycle shifts the working register by 1 (SLL: zero-fill LSB; SRL: logical, zero-fill MSB) and decrements the count.
  - When the count reaches 0, result_o is loaded and state -> DONE.
  - valid_o first high k+1 cycles after acceptance.
- zero_o: registered together with result_o.
- DONE: result_o, zero_o and valid_o are held stable until ready_i is high at an edge; then state -> IDLE. No new request is accepted in that same cycle, so maximum throughput is one op per 2 cycles.
- valid_i high while busy: ignored. The requester must hold it until ready_o is high.
- rst_i low during SHIFT or DONE: reset takes priority over every other event in that cycle.

Optional Feature:
ALU_OVERFLOW_EN
- Defined:
  - Adds output overflow_o (1 bit), registered with result_o, reset 0.
  - ADD: high when both operands have equal sign bits and the result sign differs.
  - SUB: high when operand signs differ and the result sign differs from src1.
  - All other ops: 0.
  - Held in DONE like result_o.
- Undefined: port absent; no overflow logic.

Test Plan:
- Reset: rst_i low for 2 cycles during a SHIFT with shamt=20 -> after release ready_o=1, valid_o=0, result_o=0, zero_o=0; no stale result ever appears.
- ADD: src1=0x00000005, src2=0xFFFFFFFB, ctrl=0010 -> valid_o one cycle later, result_o=0, zero_o=1. With ALU_OVERFLOW_EN, also 0x7FFFFFFF+1 -> result 0x80000000, overflow_o=1.
- SLT signed: src1=0xFFFFFFFF, src2=0x00000001 -> result_o=1. Swap operands -> 0. SUB 7-7 -> result 0, zero_o=1.
- Shifts:
  - SLL src2=0x00000001, shamt=31 -> valid_o exactly 32 cycles after acceptance, result 0x80000000, ready_o low throughout.
  - SRL src2=0x80000000, shamt=4 -> 0x08000000.
  - SLL shamt=0 -> src2 in 1 cycle.
- Backpressure: hold ready_i=0 for 5 cycles in DONE with NAND 0xFFFF0000/0xFF00FF00 -> result_o=0x00FFFFFF stable and valid_o high; valid_i pulses during this time are not accepted. ready_i=1 -> IDLE next cycle.
- Input capture: change src2 and ctrl_i mid-shift (SRL 0xF0000000 by 8) -> result still 0x00F00000; undefined ctrl=0011 -> result 0 after 1 cycle.
